// File: rtl/bcd_pkg.sv
// Shared command codes, scheduler states and helpers for the BCD adder front end.
package bcd_pkg;

  // Command codes double as the bit index of the matching req/ack line.
  typedef enum logic [2:0] {
    CMD_INIT    = 3'd0,
    CMD_LOAD_A  = 3'd1,
    CMD_LOAD_B  = 3'd2,
    CMD_DISP_A  = 3'd3,
    CMD_DISP_B  = 3'd4,
    CMD_DISP_LS = 3'd5,
    CMD_DISP_MS = 3'd6,
    CMD_NONE    = 3'd7
  } cmdT;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_REQ,
    ST_REL
  } stateT;

  localparam int NUM_SRC = 4;  // load A, load B, display LS, display MS
  localparam int NUM_REQ = 7;  // every code except CMD_NONE has a req/ack pair

  // A load is always followed by a display of the operand just loaded.
  function automatic cmdT followUp(input cmdT cmd);
    case (cmd)
      CMD_LOAD_A: followUp = CMD_DISP_A;
      CMD_LOAD_B: followUp = CMD_DISP_B;
      default:    followUp = CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_cmd_fifo.sv
// Command queue between the edge detectors and the handshake engine.
// First-word-fall-through: popData shows the head entry whenever not empty.
module bcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == FULL_LEVEL);
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  // Storage write port.
  // NOTE: the array has no reset; count/pointers alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
  // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bcd_cmd_scheduler.sv
// Queues debounced board commands and issues them to the BCD datapath over a
// four-phase req/ack handshake, adding the display step after each load and
// aborting any phase that waits TIMEOUT cycles.
module bcd_cmd_scheduler
  import bcd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_a_in,
  input  logic                   load_b_in,
  input  logic                   disp_ls_in,
  input  logic                   disp_ms_in,
  output logic                   init_req,
  output logic                   load_a_req,
  output logic                   load_b_req,
  output logic                   disp_a_req,
  output logic                   disp_b_req,
  output logic                   disp_ls_req,
  output logic                   disp_ms_req,
  input  logic                   init_ack,
  input  logic                   load_a_ack,
  input  logic                   load_b_ack,
  input  logic                   disp_a_ack,
  input  logic                   disp_b_ack,
  input  logic                   disp_ls_ack,
  input  logic                   disp_ms_ack,
  output logic [2:0]             cur_cmd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   err_timeout,
  output logic                   overrun
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  // Source bit order is also push priority: index 0 wins.
  logic [NUM_SRC-1:0] srcIn;
  logic [NUM_SRC-1:0] sampleReg;
  logic [NUM_SRC-1:0] prevReg;
  logic [NUM_SRC-1:0] pendingReg;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pushSel;
  cmdT                pushCmd;
  logic               pushEn;

  logic               fifoFull;
  logic               fifoEmpty;
  logic               fifoPop;
  logic [2:0]         fifoData;

  stateT              state, stateNext;
  cmdT                curCmd, cmdNext;
  logic [TW-1:0]      timer, timerNext;
  logic               errSet;
  logic               activeAck;
  logic [7:0]         ackVec;
  logic [NUM_REQ-1:0] reqVec;

  assign srcIn = {disp_ms_in, disp_ls_in, load_b_in, load_a_in};
  assign rise  = sampleReg & ~prevReg;

  // Highest-priority pending source becomes the push candidate.
  always_comb begin
    pushSel = '0;
    pushCmd = CMD_NONE;
    if (pendingReg[0]) begin
      pushSel = 4'b0001;
      pushCmd = CMD_LOAD_A;
    end else if (pendingReg[1]) begin
      pushSel = 4'b0010;
      pushCmd = CMD_LOAD_B;
    end else if (pendingReg[2]) begin
      pushSel = 4'b0100;
      pushCmd = CMD_DISP_LS;
    end else if (pendingReg[3]) begin
      pushSel = 4'b1000;
      pushCmd = CMD_DISP_MS;
    end
  end

  // While the queue is full, pending bits simply wait; nothing is lost.
  assign pushEn = (|pendingReg) && !fifoFull;

  // Input sampling, rising-edge capture into pending bits, coalescing flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sampleReg  <= '0;
      prevReg    <= '0;
      pendingReg <= '0;
      overrun    <= 1'b0;
    end else begin
      sampleReg  <= srcIn;
      prevReg    <= sampleReg;
      pendingReg <= (pendingReg & ~(pushEn ? pushSel : '0)) | rise;
      // A bit being pushed this cycle is no longer pending, so a fresh edge there is not a coalesce.
      if (|(rise & pendingReg & ~(pushEn ? pushSel : '0))) begin
        overrun <= 1'b1;
      end
    end
  end

  bcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (pushEn),
    .pushData (pushCmd),
    .pop      (fifoPop),
    .popData  (fifoData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (q_count)
  );

  // Acks on lines other than the active command's are ignored by construction.
  assign ackVec    = {1'b0, disp_ms_ack, disp_ls_ack, disp_b_ack, disp_a_ack,
                      load_b_ack, load_a_ack, init_ack};
  assign activeAck = ackVec[curCmd];

  // Handshake sequencing: next state, command, phase timer and abort decision.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    cmdNext   = curCmd;
    timerNext = timer;
    errSet    = 1'b0;
    fifoPop   = 1'b0;
    case (state)
      ST_INIT: begin
        stateNext = ST_REQ;
        cmdNext   = CMD_INIT;
        timerNext = '0;
      end
      ST_IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          cmdNext   = cmdT'(fifoData);
          stateNext = ST_REQ;
          timerNext = '0;
        end
      end
      ST_REQ: begin
        if (activeAck) begin
          stateNext = ST_REL;
          timerNext = '0;
        end else if (timer == TIMER_LAST) begin
          stateNext = ST_IDLE;
          cmdNext   = CMD_NONE;
          errSet    = 1'b1;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      ST_REL: begin
        if (!activeAck) begin
          timerNext = '0;
          if (followUp(curCmd) != CMD_NONE) begin
            cmdNext   = followUp(curCmd);
            stateNext = ST_REQ;
          end else begin
            cmdNext   = CMD_NONE;
            stateNext = ST_IDLE;
          end
        end else if (timer == TIMER_LAST) begin
          // Abort drops any pending follow-up along with the command.
          stateNext = ST_IDLE;
          cmdNext   = CMD_NONE;
          errSet    = 1'b1;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      default: begin
        stateNext = ST_IDLE;
        cmdNext   = CMD_NONE;
      end
    endcase
  end

  // Scheduler state register; busy is registered so it reads 0 while held in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_INIT;
      curCmd      <= CMD_NONE;
      timer       <= '0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state  <= stateNext;
      curCmd <= cmdNext;
      timer  <= timerNext;
      busy   <= (stateNext != ST_IDLE);
      if (errSet) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // One-hot req decode of the active command; only the REQ phase drives a line.
  always_comb begin
    reqVec = '0;
    if (state == ST_REQ && curCmd != CMD_NONE) begin
      reqVec[curCmd] = 1'b1;
    end
  end

  assign init_req    = reqVec[CMD_INIT];
  assign load_a_req  = reqVec[CMD_LOAD_A];
  assign load_b_req  = reqVec[CMD_LOAD_B];
  assign disp_a_req  = reqVec[CMD_DISP_A];
  assign disp_b_req  = reqVec[CMD_DISP_B];
  assign disp_ls_req = reqVec[CMD_DISP_LS];
  assign disp_ms_req = reqVec[CMD_DISP_MS];
  assign cur_cmd     = curCmd;

endmodule

// File: tb/tb_bcd_cmd_scheduler.sv
// Bench for bcd_cmd_scheduler: directed scenarios plus random command bursts,
// with a datapath responder and a transaction-order model of expected commands.
module tb_bcd_cmd_scheduler;
  import bcd_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic clock = 1'b0;
  logic reset;
  logic load_a_in, load_b_in, disp_ls_in, disp_ms_in;
  logic init_req, load_a_req, load_b_req, disp_a_req, disp_b_req, disp_ls_req, disp_ms_req;
  logic [6:0] ackVec;
  logic       initAckMain;
  logic [2:0] cur_cmd;
  logic       busy;
  logic [$clog2(DEPTH):0] q_count;
  logic       err_timeout;
  logic       overrun;
  logic [6:0] reqVec;

  int   compared   = 0;
  int   mismatched = 0;
  bit   ackEnable  = 1'b0;
  logic [6:0] noAckMask = '0;
  int   qPeak = 0;
  int   obsQ[$];
  int   expQ[$];

  assign reqVec = {disp_ms_req, disp_ls_req, disp_b_req, disp_a_req, load_b_req, load_a_req, init_req};

  always #5 clock = ~clock;

  bcd_cmd_scheduler #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load_a_in   (load_a_in),
    .load_b_in   (load_b_in),
    .disp_ls_in  (disp_ls_in),
    .disp_ms_in  (disp_ms_in),
    .init_req    (init_req),
    .load_a_req  (load_a_req),
    .load_b_req  (load_b_req),
    .disp_a_req  (disp_a_req),
    .disp_b_req  (disp_b_req),
    .disp_ls_req (disp_ls_req),
    .disp_ms_req (disp_ms_req),
    .init_ack    (ackVec[0] | initAckMain),
    .load_a_ack  (ackVec[1]),
    .load_b_ack  (ackVec[2]),
    .disp_a_ack  (ackVec[3]),
    .disp_b_ack  (ackVec[4]),
    .disp_ls_ack (ackVec[5]),
    .disp_ms_ack (ackVec[6]),
    .cur_cmd     (cur_cmd),
    .busy        (busy),
    .q_count     (q_count),
    .err_timeout (err_timeout),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic driveSrc(input logic [3:0] m);
    load_a_in  = m[0];
    load_b_in  = m[1];
    disp_ls_in = m[2];
    disp_ms_in = m[3];
  endtask

  task automatic pulse(input logic [3:0] m, input int width);
    driveSrc(m);
    tick(width);
    driveSrc(4'b0000);
  endtask

  task automatic waitReq(input string tag, input int idx, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (reqVec[idx]) seen = 1'b1;
    end
    check(tag, 32'(seen), 1);
  endtask

  // Idle means quiet for two consecutive samples: no handshake and an empty queue.
  task automatic waitIdle(input string tag, input int budget);
    int quiet = 0;
    tick(4);
    for (int i = 0; i < budget && quiet < 2; i++) begin
      @(negedge clock);
      if (!busy && q_count == 0) quiet++;
      else quiet = 0;
    end
    check(tag, 32'(quiet >= 2), 1);
  endtask

  // Expected issue order for one burst of simultaneous rising edges.
  task automatic modelBurst(input logic [3:0] m);
    if (m[0]) begin expQ.push_back(int'(CMD_LOAD_A)); expQ.push_back(int'(CMD_DISP_A)); end
    if (m[1]) begin expQ.push_back(int'(CMD_LOAD_B)); expQ.push_back(int'(CMD_DISP_B)); end
    if (m[2]) expQ.push_back(int'(CMD_DISP_LS));
    if (m[3]) expQ.push_back(int'(CMD_DISP_MS));
  endtask

  task automatic compareSeq(input string tag);
    check({tag, "_len"}, 32'(obsQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), 32'(obsQ[i]), 32'(expQ[i]));
    end
    obsQ.delete();
    expQ.delete();
  endtask

  // Monitor: records each req assertion and tracks queue occupancy peak.
  initial begin : monitor
    logic [6:0] prevReq;
    prevReq = '0;
    forever begin
      @(negedge clock);
      check("req_onehot", 32'($onehot0(reqVec)), 1);
      for (int i = 0; i < 7; i++) begin
        if (reqVec[i] && !prevReq[i]) obsQ.push_back(i);
      end
      if (int'(q_count) > qPeak) qPeak = int'(q_count);
      prevReq = reqVec;
    end
  end

  // Datapath model: answers the active req with randomly delayed four-phase acks.
  initial begin : responder
    ackVec = '0;
    forever begin
      @(negedge clock);
      if (ackEnable && !reset && reqVec != '0) begin
        int idx;
        idx = 0;
        for (int i = 0; i < 7; i++) if (reqVec[i]) idx = i;
        if (!noAckMask[idx]) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          ackVec[idx] = 1'b1;
          for (int i = 0; i < 64 && reqVec[idx]; i++) @(negedge clock);
          repeat ($urandom_range(0, 3)) @(negedge clock);
          ackVec[idx] = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [3:0] m;
    int highCycles;

    reset       = 1'b1;
    initAckMain = 1'b0;
    driveSrc(4'b0000);

    // Reset values and the INIT handshake.
    #23;
    check("rst_req",     32'(reqVec), 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_cur_cmd", 32'(cur_cmd), 7);
    check("rst_q_count", 32'(q_count), 0);
    check("rst_err",     32'(err_timeout), 0);
    check("rst_overrun", 32'(overrun), 0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      check($sformatf("init_req_c%0d", c), 32'(init_req), 1);
    end
    check("init_cur_cmd", 32'(cur_cmd), 0);
    initAckMain = 1'b1;
    @(negedge clock);
    check("init_req_dropped", 32'(init_req), 0);
    check("init_busy_rel", 32'(busy), 1);
    initAckMain = 1'b0;
    @(negedge clock);
    check("init_busy_done", 32'(busy), 0);
    check("init_err", 32'(err_timeout), 0);
    check("init_cur_cmd_none", 32'(cur_cmd), 7);
    expQ.push_back(int'(CMD_INIT));
    compareSeq("init_seq");

    // Load A chain with exact input-to-req latency.
    driveSrc(4'b0001);
    @(negedge clock);
    driveSrc(4'b0000);
    @(negedge clock);
    check("lat_k1_q", 32'(q_count), 0);
    @(negedge clock);
    check("lat_k2_q", 32'(q_count), 1);
    check("lat_k2_req", 32'(load_a_req), 0);
    @(negedge clock);
    check("lat_k3_req", 32'(load_a_req), 1);
    check("lat_k3_cmd", 32'(cur_cmd), 1);
    check("lat_k3_q", 32'(q_count), 0);
    check("lat_k3_busy", 32'(busy), 1);
    ackEnable = 1'b1;
    waitReq("chain_disp_a", 3, 40);
    check("chain_cmd_disp_a", 32'(cur_cmd), 3);
    waitIdle("chain_idle", 100);
    check("chain_cmd_none", 32'(cur_cmd), 7);
    check("chain_q_empty", 32'(q_count), 0);
    modelBurst(4'b0001);
    compareSeq("chain_seq");

    // All four sources rise together while a DISP_MS handshake is stalled.
    ackEnable = 1'b0;
    pulse(4'b1000, 1);
    waitReq("simul_stall", 6, 10);
    qPeak = 0;
    pulse(4'b1111, 1);
    tick(6);
    check("simul_q_full", 32'(q_count), 4);
    ackEnable = 1'b1;
    waitIdle("simul_idle", 400);
    check("simul_q_peak", 32'(qPeak), 4);
    expQ.push_back(int'(CMD_DISP_MS));
    modelBurst(4'b1111);
    compareSeq("simul_seq");

    // Random bursts of simultaneous edges with random ack latencies.
    for (int it = 0; it < 16; it++) begin
      m = 4'($urandom_range(1, 15));
      modelBurst(m);
      pulse(m, int'($urandom_range(1, 3)));
      waitIdle($sformatf("rand%0d_idle", it), 400);
      compareSeq($sformatf("rand%0d_seq", it));
    end
    check("rand_err", 32'(err_timeout), 0);
    check("rand_overrun", 32'(overrun), 0);

    // Overrun: fill the queue behind a stalled DISP_LS, then coalesce one more edge.
    ackEnable = 1'b0;
    for (int p = 0; p < 7; p++) begin
      disp_ls_in = 1'b1;
      @(negedge clock);
      disp_ls_in = 1'b0;
      @(negedge clock);
    end
    check("ovr_q_full", 32'(q_count), 4);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_stalled_req", 32'(disp_ls_req), 1);
    ackEnable = 1'b1;
    waitIdle("ovr_idle", 600);
    for (int p = 0; p < 6; p++) expQ.push_back(int'(CMD_DISP_LS));
    compareSeq("ovr_seq");
    check("ovr_err", 32'(err_timeout), 0);

    // Timeout: LOAD_B is never acknowledged; DISP_MS queued behind it still issues.
    noAckMask = 7'b0000100;
    pulse(4'b1010, 1);
    waitReq("to_req", 2, 10);
    highCycles = 1;
    for (int i = 0; i < 4 * TIMEOUT && load_b_req; i++) begin
      @(negedge clock);
      if (load_b_req) highCycles++;
    end
    check("to_req_cycles", 32'(highCycles), 32'(TIMEOUT));
    check("to_err", 32'(err_timeout), 1);
    waitIdle("to_idle", 200);
    noAckMask = '0;
    expQ.push_back(int'(CMD_LOAD_B));
    expQ.push_back(int'(CMD_DISP_MS));
    compareSeq("to_seq");

    // Reset in the middle of a DISP_MS handshake with two commands queued.
    ackEnable = 1'b0;
    pulse(4'b1000, 1);
    waitReq("mid_req", 6, 10);
    pulse(4'b0011, 1);
    tick(4);
    check("mid_q_count", 32'(q_count), 2);
    check("mid_req_high", 32'(disp_ms_req), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_async_req", 32'(reqVec), 0);
    check("mid_async_busy", 32'(busy), 0);
    @(negedge clock);
    check("mid_rst_q", 32'(q_count), 0);
    check("mid_rst_err", 32'(err_timeout), 0);
    check("mid_rst_ovr", 32'(overrun), 0);
    check("mid_rst_cmd", 32'(cur_cmd), 7);
    reset = 1'b0;
    @(negedge clock);
    check("mid_init_req", 32'(init_req), 1);
    check("mid_init_cmd", 32'(cur_cmd), 0);
    ackEnable = 1'b1;
    waitIdle("mid_idle", 200);
    expQ.push_back(int'(CMD_DISP_MS));
    expQ.push_back(int'(CMD_INIT));
    compareSeq("mid_seq");
    check("end_err", 32'(err_timeout), 0);
    check("end_overrun", 32'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
